// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Tick indices inside a bit period where the line is sampled for the majority vote.
  localparam logic [4:0] SMP_A = 5'd6;
  localparam logic [4:0] SMP_B = 5'd7;
  localparam logic [4:0] SMP_C = 5'd8;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled serial receiver: start/data/stop recovery with 3-sample majority,
// false-start rejection, framing-error flag and break hold-off.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [4:0] S_LAST      = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

  rx_state_t  state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic [2:0] smp_q, smp_d;
  logic       done_q, done_d;
  logic [7:0] dout_q, dout_d;
  logic       ferr_q, ferr_d;
  logic       rx_s;
  logic       maj_live;
  logic       maj_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // At s == SMP_C the third sample is still on the line, so the start check votes on it live.
  assign maj_live = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign maj_q    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    smp_d   = smp_q;

    if (s_tick && (state_q == START || state_q == DATA || state_q == STOP)) begin
      case (s_q)
        SMP_A:   smp_d[0] = rx_s;
        SMP_B:   smp_d[1] = rx_s;
        SMP_C:   smp_d[2] = rx_s;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SMP_C && maj_live) begin
            state_d = IDLE;
          end else if (s_q == S_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {maj_q, b_q[7:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            state_d = maj_q ? IDLE : BREAK;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d = 1'b0;
    dout_d = dout_q;
    ferr_d = ferr_q;
    if (state_q == STOP && s_tick && s_q == S_STOP_LAST) begin
      done_d = 1'b1;
      dout_d = b_q >> (8 - DBIT);
      ferr_d = ~maj_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q    <= '0;
      n_q    <= '0;
      b_q    <= '0;
      smp_q  <= '0;
      done_q <= 1'b0;
      dout_q <= '0;
      ferr_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      n_q    <= n_d;
      b_q    <= b_d;
      smp_q  <= smp_d;
      done_q <= done_d;
      dout_q <= dout_d;
      ferr_q <= ferr_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: default (8 bits, 1 stop) and DBIT=7/SB_TICK=32 instances.
`timescale 1ns/1ps
module tb_uart_rx;

  typedef struct {
    logic [7:0] dout;
    logic       ferr;
    int         ticks;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       done_a, ferr_a, busy_a;
  logic       done_b, ferr_b, busy_b;
  logic [7:0] dout_a, dout_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   ticks_a = 0;
  int   ticks_b = 0;
  int   tick_phase = 0;

  uart_rx dut_a (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx_a),
    .rx_done_tick (done_a),
    .dout         (dout_a),
    .frame_err    (ferr_a),
    .rx_busy      (busy_a)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx_b),
    .rx_done_tick (done_b),
    .dout         (dout_b),
    .frame_err    (ferr_b),
    .rx_busy      (busy_b)
  );

  always #5 clk = ~clk;

  // Baud strobe: one clk high every 4 clk, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_phase = (tick_phase + 1) % 4;
      s_tick = (tick_phase == 0);
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every done pulse; ticks counts strobes seen while busy.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_pulse", {31'b0, done_a}, 32'd0);
        end else begin
          e_a = q_a.pop_front();
          check("a_dout", {24'b0, dout_a}, {24'b0, e_a.dout});
          check("a_frame_err", {31'b0, ferr_a}, {31'b0, e_a.ferr});
          check("a_pulse_ticks", ticks_a, e_a.ticks);
        end
        ticks_a = 0;
      end else if (busy_a && s_tick) begin
        ticks_a++;
      end else if (!busy_a) begin
        ticks_a = 0;
      end

      if (done_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_pulse", {31'b0, done_b}, 32'd0);
        end else begin
          e_b = q_b.pop_front();
          check("b_dout", {24'b0, dout_b}, {24'b0, e_b.dout});
          check("b_frame_err", {31'b0, ferr_b}, {31'b0, e_b.ferr});
          check("b_pulse_ticks", ticks_b, e_b.ticks);
        end
        ticks_b = 0;
      end else if (busy_b && s_tick) begin
        ticks_b++;
      end else if (!busy_b) begin
        ticks_b = 0;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int unit, input logic v);
    if (unit == 0) rx_a = v;
    else           rx_b = v;
  endtask

  // One frame at 64 clk/bit; glitch_bit >= 0 inverts that data bit for 4 clk mid-bit.
  task automatic send(input int unit, input logic [7:0] data, input logic stop_val,
                      input int glitch_bit);
    int   nb = (unit == 0) ? 8 : 7;
    int   sb = (unit == 0) ? 16 : 32;
    exp_t e;
    e.dout  = 8'(int'(data) % (1 << nb));
    e.ferr  = ~stop_val;
    e.ticks = 16 + 16 * nb + sb;
    if (unit == 0) q_a.push_back(e);
    else           q_b.push_back(e);
    drive(unit, 1'b0);
    wait_clk(64);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) begin
        drive(unit, data[i]);
        wait_clk(30);
        drive(unit, ~data[i]);
        wait_clk(4);
        drive(unit, data[i]);
        wait_clk(30);
      end else begin
        drive(unit, data[i]);
        wait_clk(64);
      end
    end
    drive(unit, stop_val);
    wait_clk(sb * 4);
    drive(unit, 1'b1);
  endtask

  initial begin
    logic [7:0] rdata;
    logic       rstop;
    int         k;
    exp_t       eb;

    wait_clk(5);
    check("rst_dout", {24'b0, dout_a}, 32'd0);
    check("rst_frame_err", {31'b0, ferr_a}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_done", {31'b0, done_a}, 32'd0);
    reset = 1'b0;
    wait_clk(20);

    send(0, 8'hA5, 1'b1, -1);
    wait_clk(64);

    send(0, 8'h00, 1'b1, -1);
    send(0, 8'hFF, 1'b1, -1);
    send(0, 8'h3C, 1'b1, -1);
    wait_clk(128);

    // One-tick low glitch on an idle line must be rejected as a false start.
    drive(0, 1'b0);
    wait_clk(4);
    drive(0, 1'b1);
    k = 0;
    while (!busy_a && k < 8) begin
      wait_clk(1);
      k++;
    end
    check("glitch_busy_rise", {31'b0, busy_a}, 32'd1);
    k = 0;
    while (busy_a && k < 40) begin
      wait_clk(1);
      k++;
    end
    check("glitch_busy_fall", {31'b0, busy_a}, 32'd0);
    wait_clk(64);

    send(0, 8'h55, 1'b1, 3);
    wait_clk(64);

    // Break: 20 bit times low gives one all-zero frame with framing error, then hold-off.
    eb.dout  = 8'h00;
    eb.ferr  = 1'b1;
    eb.ticks = 160;
    q_a.push_back(eb);
    drive(0, 1'b0);
    wait_clk(20 * 64);
    check("break_hold_busy", {31'b0, busy_a}, 32'd1);
    drive(0, 1'b1);
    wait_clk(8);
    check("break_exit_idle", {31'b0, busy_a}, 32'd0);
    wait_clk(120);
    send(0, 8'h81, 1'b1, -1);
    wait_clk(64);

    send(1, 8'h5A, 1'b1, -1);
    wait_clk(128);

    // Reset in the middle of data bit 4.
    rdata = 8'h6B;
    drive(0, 1'b0);
    wait_clk(64);
    for (int i = 0; i < 4; i++) begin
      drive(0, rdata[i]);
      wait_clk(64);
    end
    drive(0, rdata[4]);
    wait_clk(32);
    check("midrst_busy_before", {31'b0, busy_a}, 32'd1);
    reset = 1'b1;
    rx_a  = 1'b1;
    wait_clk(3);
    check("midrst_dout", {24'b0, dout_a}, 32'd0);
    check("midrst_frame_err", {31'b0, ferr_a}, 32'd0);
    check("midrst_busy", {31'b0, busy_a}, 32'd0);
    check("midrst_done", {31'b0, done_a}, 32'd0);
    reset = 1'b0;
    wait_clk(128);
    send(0, 8'h42, 1'b1, -1);
    wait_clk(64);

    for (int f = 0; f < 10; f++) begin
      rdata = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      send(0, rdata, rstop, -1);
      if (rstop) wait_clk($urandom_range(0, 80));
      else       wait_clk(64 + $urandom_range(0, 40));
    end
    for (int f = 0; f < 3; f++) begin
      rdata = 8'($urandom_range(0, 255));
      send(1, rdata, 1'b1, -1);
      wait_clk($urandom_range(0, 80));
    end

    k = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && k < 400) begin
      wait_clk(1);
      k++;
    end
    wait_clk(64);
    check("a_all_frames_seen", q_a.size(), 32'd0);
    check("b_all_frames_seen", q_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
